// File: rtl/data_mem_port_pkg.sv
// Shared definitions for the data-memory port: data-path width and the
// default number of wait cycles a memory access takes.
package data_mem_port_pkg;

    localparam int DATA_W      = 32;
    localparam int MEM_LATENCY = 2;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/data_mem_port_dmem_bank.sv
// Word-organised, byte-writable single-port RAM with a registered read port.
// The read register is the port's DataOut and only changes on a read commit.
module dmem_bank
    import data_mem_port_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [3:0]            be_i,
    input  logic                  we_i,
    input  logic                  strobe_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_W-1:0] rdata_q;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (strobe_i && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (strobe_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_port.sv
// Data-memory port: accepts one access from the MEM-stage controller, holds it
// busy for LATENCY wait cycles, then commits to the RAM bank in a single DONE cycle.
module data_mem_port
    import data_mem_port_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = MEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       Address,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              ReadEnable,
    input  logic [3:0]        WriteEnable,
    output logic [DATA_W-1:0] DataOut,
    output logic              MemReady
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);
    localparam bit               NO_WAIT = (LATENCY == 0);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [3:0]            be_q, be_d;
    logic                  wr_q, wr_d;

    logic                  req;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] bank_addr;
    logic [DATA_W-1:0]     bank_wdata;
    logic [3:0]            bank_be;
    logic                  bank_we;
    logic                  unused_addr_bits;

    assign req              = ReadEnable | (|WriteEnable);
    assign unused_addr_bits = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

    assign MemReady = ((state_q == ST_IDLE) && req) || (state_q == ST_WAIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        be_d    = be_q;
        wr_d    = wr_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    idx_d   = Address[ADDR_WIDTH+1:2];
                    data_d  = DataIn;
                    be_d    = WriteEnable;
                    wr_d    = |WriteEnable;
                    cnt_d   = LAT_CNT;
                    state_d = NO_WAIT ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
        end
    end

    // The commit edge is the DONE-entry edge. With no wait cycles it coincides
    // with acceptance, so the bank is fed straight from the inputs while idle.
    assign commit = !rst && (((state_q == ST_WAIT) && (cnt_q == CNT_W'(1))) ||
                             ((state_q == ST_IDLE) && req && NO_WAIT));

    assign bank_addr  = (state_q == ST_IDLE) ? Address[ADDR_WIDTH+1:2] : idx_q;
    assign bank_wdata = (state_q == ST_IDLE) ? DataIn                  : data_q;
    assign bank_be    = (state_q == ST_IDLE) ? WriteEnable             : be_q;
    assign bank_we    = (state_q == ST_IDLE) ? (|WriteEnable)          : wr_q;

    dmem_bank #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .addr_i  (bank_addr),
        .wdata_i (bank_wdata),
        .be_i    (bank_be),
        .we_i    (bank_we),
        .strobe_i(commit),
        .rdata_o (DataOut)
    );

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: one instance with no wait cycles, one with two.
module tb_data_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        re   [2];
    logic [3:0]  we   [2];
    logic [31:0] addr [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic        mr   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_port #(.ADDR_WIDTH(10), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst), .Address(addr[0]), .DataIn(din[0]),
        .ReadEnable(re[0]), .WriteEnable(we[0]), .DataOut(dout[0]), .MemReady(mr[0])
    );

    data_mem_port #(.ADDR_WIDTH(10), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst), .Address(addr[1]), .DataIn(din[1]),
        .ReadEnable(re[1]), .WriteEnable(we[1]), .DataOut(dout[1]), .MemReady(mr[1])
    );

    typedef struct {
        string       nm;
        int          d;
        logic        r;
        logic [3:0]  w;
        logic [31:0] a;
        logic [31:0] dat;
        int          busy;
        logic [31:0] dq;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one access on a negedge, count cycles with MemReady high (enables
    // dropped after acceptance) and return DataOut in the DONE cycle.
    task automatic access(input int d, input logic r, input logic [3:0] w,
                          input logic [31:0] a, input logic [31:0] dat,
                          output int busy, output logic [31:0] dq);
        @(negedge clk);
        re[d] = r; we[d] = w; addr[d] = a; din[d] = dat;
        #1;
        busy = 0;
        while (mr[d] && busy < 40) begin
            busy++;
            @(posedge clk);
            #1;
            re[d] = 1'b0;
            we[d] = 4'h0;
            @(negedge clk);
        end
        dq = dout[d];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          busy;
        logic [31:0] dq;
        logic [31:0] lb;
        logic [1:0]  lane;
        logic        mrexp [8];

        tbl[0]  = '{"wr_10",        1, 1'b0, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 3, 32'h0000_0000};
        tbl[1]  = '{"wr_20",        1, 1'b0, 4'hF, 32'h0000_0020, 32'h1122_3344, 3, 32'h0000_0000};
        tbl[2]  = '{"rd_10",        1, 1'b1, 4'h0, 32'h0000_0010, 32'h0,         3, 32'hDEAD_BEEF};
        tbl[3]  = '{"wr_20_byte2",  1, 1'b0, 4'h4, 32'h0000_0020, 32'h5A5A_5A5A, 3, 32'hDEAD_BEEF};
        tbl[4]  = '{"rd_20",        1, 1'b1, 4'h0, 32'h0000_0020, 32'h0,         3, 32'h115A_3344};
        tbl[5]  = '{"l0_wr_3fc",    0, 1'b0, 4'hF, 32'h0000_03FC, 32'hCAFE_F00D, 1, 32'h0000_0000};
        tbl[6]  = '{"l0_rd_3fc",    0, 1'b1, 4'h0, 32'h0000_03FC, 32'h0,         1, 32'hCAFE_F00D};
        tbl[7]  = '{"l0_rd_13fc",   0, 1'b1, 4'h0, 32'h0000_13FC, 32'h0,         1, 32'hCAFE_F00D};
        tbl[8]  = '{"wr_40_zero",   1, 1'b0, 4'hF, 32'h0000_0040, 32'h0000_0000, 3, 32'h115A_3344};
        tbl[9]  = '{"wr_20_byte3",  1, 1'b0, 4'h8, 32'h0000_0020, 32'h8080_8080, 3, 32'h115A_3344};
        tbl[10] = '{"rd_23",        1, 1'b1, 4'h0, 32'h0000_0023, 32'h0,         3, 32'h805A_3344};

        mrexp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        for (int i = 0; i < 2; i++) begin
            re[i] = 1'b0; we[i] = 4'h0; addr[i] = '0; din[i] = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_mr_l0", 32'(mr[0]), 32'd0);
        chk("reset_mr_l2", 32'(mr[1]), 32'd0);
        chk("reset_dout_l0", dout[0], 32'h0);
        chk("reset_dout_l2", dout[1], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_req_mr", 32'(mr[1]), 32'd0);

        for (int i = 0; i < 11; i++) begin
            access(tbl[i].d, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].dat, busy, dq);
            chk({tbl[i].nm, "_busy"}, 32'(busy), 32'(tbl[i].busy));
            chk({tbl[i].nm, "_dout"}, dq, tbl[i].dq);
        end

        // Sign-extended byte load at 0x23 as the CPU would see it.
        access(1, 1'b1, 4'h0, 32'h0000_0023, 32'h0, busy, dq);
        lane = 2'd3;
        lb = {{24{dq[8*lane+7]}}, dq[8*lane +: 8]};
        chk("lb_23_busy", 32'(busy), 32'd3);
        chk("lb_23_value", lb, 32'hFFFF_FF80);

        // Read+write conflict with ReadEnable held through DONE.
        @(negedge clk);
        re[1] = 1'b1; we[1] = 4'hF; addr[1] = 32'h0000_0050; din[1] = 32'h1234_5678;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("held_mr_c%0d", i), 32'(mr[1]), 32'(mrexp[i]));
            if (i == 3) chk("conflict_dout_unchanged", dout[1], 32'h805A_3344);
            if (i == 7) begin
                chk("held_read_dout", dout[1], 32'h1234_5678);
                re[1] = 1'b0;
            end
            @(posedge clk);
            #1;
            we[1] = 4'h0;
            @(negedge clk);
        end

        // Reset in the first WAIT cycle of a write: nothing committed.
        @(negedge clk);
        re[1] = 1'b0; we[1] = 4'hF; addr[1] = 32'h0000_0040; din[1] = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        we[1] = 4'h0;
        @(negedge clk);
        chk("pre_reset_mr", 32'(mr[1]), 32'd1);
        rst = 1'b1;
        #1;
        chk("midreset_mr", 32'(mr[1]), 32'd0);
        chk("midreset_dout", dout[1], 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        access(1, 1'b1, 4'h0, 32'h0000_0040, 32'h0, busy, dq);
        chk("after_reset_rd40_busy", 32'(busy), 32'd3);
        chk("after_reset_rd40_dout", dq, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
